uart_bus_responder: RTL and testbench

On-FPGA UART device that answers the CPU memory controller's serial-port bus: active-low `rdn`/`wrn` strobes plus `data_ready`, `tbre`, `tsre` status flags. It is the device end of that handshake, replacing the external UART chip. The block converts bytes written by the host into 8N1 serial frames on `txd`, and assembles 8N1 frames from `rxd` into a readable byte.

---
 rtl/uart_bus_responder_if.sv | 33 +++
 rtl/uart_bus_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_responder_if.sv
// ---------------------------------------------------------------------------
// uart_bus_responder_if
//   Host-side serial-port bus between the CPU memory controller (master) and
//   the on-FPGA UART device (slave).
//
//   wrn, rdn    : active-low write / read strobes from the host
//   data_i[7:0] : write data from the host (low byte of the data bus)
//   data_o[7:0] : receive buffer contents presented to the host
//   data_oe     : host-side bus drive enable (follows ~rdn combinationally)
//   tbre        : transmit holding register empty
//   tsre        : transmit shift register empty (no frame in progress)
//   data_ready  : receive buffer holds an unread byte
// ---------------------------------------------------------------------------
interface uart_bus_responder_if;
    logic       wrn;
    logic       rdn;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_oe;
    logic       tbre;
    logic       tsre;
    logic       data_ready;

    modport master (
        output wrn, rdn, data_i,
        input  data_o, data_oe, tbre, tsre, data_ready
    );

    modport slave (
        input  wrn, rdn, data_i,
        output data_o, data_oe, tbre, tsre, data_ready
    );
endinterface

// File: rtl/uart_bus_responder.sv
// ---------------------------------------------------------------------------
// uart_bus_responder
//   Device end of the CPU serial-port handshake. Bytes written by the host
//   are sent as 8N1 frames on txd; 8N1 frames arriving on rxd are assembled
//   into a byte the host can read.
//
//   Parameters : CLK_DIV  clock cycles per bit (>= 4)
//   Ports      : clk_50MHz    system clock (rising edge)
//                rst          asynchronous, active-low reset
//                bus          host bus (slave modport of uart_bus_responder_if)
//                txd          serial transmit line, idle high
//                rxd          serial receive line (asynchronous)
//                overrun_err  1-cycle pulse: new byte overwrote an unread one
//                frame_err    1-cycle pulse: received stop bit was 0
// ---------------------------------------------------------------------------
module uart_bus_responder #(
    parameter int CLK_DIV = 434
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    uart_bus_responder_if.slave   bus,
    output logic                  txd,
    input  logic                  rxd,
    output logic                  overrun_err,
    output logic                  frame_err
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    // The start bit is re-checked CLK_DIV/2 cycles after the falling edge;
    // from there, whole-bit steps land every later sample at mid-bit.
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLK_DIV / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    // Strobe edge detect
    logic wrn_q, rdn_q;
    logic wr_evt, rd_evt;

    // Transmit path
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    state_e            tx_state_q, tx_state_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic              txd_q, txd_d;
    logic              tsre_q, tsre_d;

    // Receive path
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic              rx_fall;
    state_e            rx_state_q, rx_state_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              data_ready_q, data_ready_d;
    logic              overrun_q, overrun_d;
    logic              frame_q, frame_d;

    // One event per strobe: registered high while the raw strobe is low.
    assign wr_evt  = wrn_q & ~bus.wrn;
    assign rd_evt  = rdn_q & ~bus.rdn;
    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // ------------------------------------------------------------------
    // Transmit next-state
    // ------------------------------------------------------------------
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        txd_d       = txd_q;
        tsre_d      = tsre_q;

        // Writes while the holding register is full are dropped.
        if (wr_evt && !hold_full_q) begin
            hold_d      = bus.data_i;
            hold_full_d = 1'b1;
        end

        case (tx_state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    // hold_full_q=1 means no write can be accepted this edge,
                    // so clearing it here never loses a byte.
                    tx_state_d  = ST_START;
                    tx_shift_d  = hold_q;
                    hold_full_d = 1'b0;
                    tsre_d      = 1'b0;
                    txd_d       = 1'b0;
                    tx_baud_d   = '0;
                end else begin
                    tsre_d = 1'b1;
                end
            end
            ST_START: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_state_d = ST_DATA;
                    tx_bit_d   = 4'd0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 4'd7) begin
                        tx_state_d = ST_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_state_d = ST_IDLE;
                    // Stay "busy" if another byte is already waiting so the
                    // back-to-back frame shows no tsre blip.
                    tsre_d     = ~hold_full_q;
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_ONE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive next-state
    // ------------------------------------------------------------------
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_shift_d   = rx_shift_q;
        rx_baud_d    = rx_baud_q;
        rx_bit_d     = rx_bit_q;
        rx_data_d    = rx_data_q;
        overrun_d    = 1'b0;
        frame_d      = 1'b0;
        data_ready_d = rd_evt ? 1'b0 : data_ready_q;

        case (rx_state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = ST_START;
                    rx_baud_d  = '0;
                end
            end
            ST_START: begin
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = 4'd0;
                    // Line back high at mid-start: treat as a glitch.
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_sync_q) begin
                        // Completion beats a same-edge read: the new byte is
                        // unread, and nothing was lost, so no overrun.
                        rx_data_d    = rx_shift_q;
                        data_ready_d = 1'b1;
                        overrun_d    = data_ready_q & ~rd_evt;
                    end else begin
                        frame_d = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_ONE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            wrn_q        <= 1'b1;
            rdn_q        <= 1'b1;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            tx_state_q   <= ST_IDLE;
            tx_shift_q   <= '0;
            tx_baud_q    <= '0;
            tx_bit_q     <= '0;
            txd_q        <= 1'b1;
            tsre_q       <= 1'b1;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_shift_q   <= '0;
            rx_baud_q    <= '0;
            rx_bit_q     <= '0;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            wrn_q        <= bus.wrn;
            rdn_q        <= bus.rdn;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            tx_state_q   <= tx_state_d;
            tx_shift_q   <= tx_shift_d;
            tx_baud_q    <= tx_baud_d;
            tx_bit_q     <= tx_bit_d;
            txd_q        <= txd_d;
            tsre_q       <= tsre_d;
            rx_meta_q    <= rxd;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_shift_q   <= rx_shift_d;
            rx_baud_q    <= rx_baud_d;
            rx_bit_q     <= rx_bit_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.data_o     = rx_data_q;
    assign bus.data_oe    = ~bus.rdn;
    assign bus.tbre       = ~hold_full_q;
    assign bus.tsre       = tsre_q;
    assign bus.data_ready = data_ready_q;
    assign txd            = txd_q;
    assign overrun_err    = overrun_q;
    assign frame_err      = frame_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_bus_responder
//   Scoreboard bench for uart_bus_responder at CLK_DIV=8. Stimulus pushes
//   expected TX bytes and RX events into queues; monitors pop and compare
//   when the DUT shows a start bit on txd or an RX event (data_ready rise,
//   overrun_err, frame_err).
// ---------------------------------------------------------------------------
module tb_uart_bus_responder;

    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic txd;
    logic overrun_err;
    logic frame_err;

    uart_bus_responder_if bus_if ();

    uart_bus_responder #(.CLK_DIV(D)) dut (
        .clk_50MHz   (clk),
        .rst         (rst),
        .bus         (bus_if),
        .txd         (txd),
        .rxd         (rxd),
        .overrun_err (overrun_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {EV_READY = 0, EV_OVR = 1, EV_FERR = 2} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
    } rx_ev_t;

    logic [7:0] tx_q[$];
    int         tx_starts[$];
    rx_ev_t     rx_q[$];
    int         last_ready_cyc = 0;
    int         rx_start_cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    function automatic logic get_flag(input int which);
        case (which)
            0:       return bus_if.tbre;
            1:       return bus_if.tsre;
            default: return bus_if.data_ready;
        endcase
    endfunction

    task automatic wait_flag(input string name, input int which, input logic val, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            if (get_flag(which) === val) break;
        end
        n_checks++;
        if (i == max) begin
            n_fail++;
            $display("FAIL %s: flag still 0x%0h after %0d cycles, expected 0x%0h", name, !val, max, val);
        end
    endtask

    task automatic push_rx(input ev_e k, input logic [7:0] d);
        rx_ev_t e;
        e.kind = k;
        e.data = d;
        rx_q.push_back(e);
    endtask

    task automatic rx_event(input ev_e k, input logic [7:0] d);
        rx_ev_t e;
        n_checks++;
        if (rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_event: got kind %0d data 0x%02h, expected no event", int'(k), d);
        end else begin
            e = rx_q.pop_front();
            if (e.kind != k || e.data !== d) begin
                n_fail++;
                $display("FAIL rx_event: got kind %0d data 0x%02h, expected kind %0d data 0x%02h",
                         int'(k), d, int'(e.kind), e.data);
            end else begin
                $display("ok   rx event kind %0d data 0x%02h", int'(k), d);
            end
        end
    endtask

    // TX monitor: compares every cycle of the frame against the expected
    // 8N1 waveform, aborting silently if reset interrupts the frame.
    initial begin : tx_mon
        logic [9:0] frame;
        logic [7:0] exp_b, act_b;
        logic       bad, had, aborted;
        int         c;
        forever begin
            @(negedge clk);
            if (rst && txd === 1'b0) begin
                tx_starts.push_back(cyc);
                had   = (tx_q.size() != 0);
                exp_b = had ? tx_q.pop_front() : 8'h00;
                frame = {1'b1, exp_b, 1'b0};
                bad = 1'b0; aborted = 1'b0; act_b = 8'h00; c = 0;
                while (c < 10 * D) begin
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd !== frame[c / D]) bad = 1'b1;
                    if ((c % D) == D / 2 && c / D >= 1 && c / D <= 8) act_b[c / D - 1] = txd;
                    c++;
                    if (c < 10 * D) @(negedge clk);
                end
                if (!aborted) begin
                    n_checks++;
                    if (!had) begin
                        n_fail++;
                        $display("FAIL tx_frame: got frame 0x%02h, expected no frame", act_b);
                    end else if (bad) begin
                        n_fail++;
                        $display("FAIL tx_frame: got txd byte 0x%02h, expected exact 8N1 frame of 0x%02h", act_b, exp_b);
                    end else begin
                        $display("ok   tx frame 0x%02h", act_b);
                    end
                end
            end
        end
    end

    // RX monitor
    initial begin : rx_mon
        logic prev_dr;
        prev_dr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_dr = 1'b0;
            end else begin
                if (bus_if.data_ready && !prev_dr) begin
                    last_ready_cyc = cyc;
                    rx_event(EV_READY, bus_if.data_o);
                end
                if (overrun_err) rx_event(EV_OVR, bus_if.data_o);
                if (frame_err)   rx_event(EV_FERR, bus_if.data_o);
                prev_dr = bus_if.data_ready;
            end
        end
    end

    task automatic host_write(input logic [7:0] b);
        @(posedge clk); #1;
        bus_if.wrn    = 1'b0;
        bus_if.data_i = b;
        @(posedge clk); #1;
        bus_if.wrn    = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        rx_start_cyc = cyc;
        rxd = 1'b0;
        repeat (D) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (D) @(posedge clk);
            #1;
        end
        rxd = stop_bit;
        repeat (D) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (D) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        int diff;
        bus_if.wrn    = 1'b1;
        bus_if.rdn    = 1'b1;
        bus_if.data_i = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_tbre", bus_if.tbre, 1);
        check("reset_tsre", bus_if.tsre, 1);
        check("reset_data_ready", bus_if.data_ready, 0);
        check("reset_txd", txd, 1);
        check("reset_data_o", bus_if.data_o, 8'h00);
        check("reset_overrun", overrun_err, 0);
        check("reset_frame_err", frame_err, 0);

        // Single TX 0xA5
        tx_q.push_back(8'hA5);
        host_write(8'hA5);
        @(negedge clk);
        check("tbre_after_write", bus_if.tbre, 0);
        @(negedge clk);
        check("tbre_at_start", bus_if.tbre, 1);
        check("tsre_at_start", bus_if.tsre, 0);
        check("txd_start_bit", txd, 0);
        repeat (79) @(negedge clk);
        check("tsre_before_80", bus_if.tsre, 0);
        @(negedge clk);
        check("tsre_at_80", bus_if.tsre, 1);

        // Back-to-back TX, third write ignored
        repeat (5) @(posedge clk);
        tx_starts.delete();
        tx_q.push_back(8'h01);
        host_write(8'h01);
        wait_flag("wait_tbre_free", 0, 1'b1, 20);
        tx_q.push_back(8'hFF);
        host_write(8'hFF);
        @(negedge clk);
        check("tbre_full", bus_if.tbre, 0);
        host_write(8'hEE);
        wait_flag("wait_tsre_busy", 1, 1'b0, 10);
        wait_flag("wait_b2b_done", 1, 1'b1, 400);
        repeat (100) @(negedge clk);
        check("b2b_frame_count", tx_starts.size(), 2);
        diff = (tx_starts.size() >= 2) ? tx_starts[1] - tx_starts[0] : 0;
        check("b2b_gap_ok", (diff >= 10 * D && diff <= 10 * D + 1), 1);
        check("tx_q_drained", tx_q.size(), 0);

        // RX normal 0x3C and read
        push_rx(EV_READY, 8'h3C);
        send_rx(8'h3C, 1'b1);
        wait_flag("wait_ready_3c", 2, 1'b1, 20);
        check("rx_data_3c", bus_if.data_o, 8'h3C);
        lat = last_ready_cyc - rx_start_cyc;
        check("rx_latency_bound", (lat > 0 && lat <= 2 + D / 2 + 9 * D + 1), 1);
        @(posedge clk); #1;
        bus_if.rdn = 1'b0;
        @(negedge clk);
        check("data_oe_during_read", bus_if.data_oe, 1);
        check("ready_before_read_edge", bus_if.data_ready, 1);
        @(negedge clk);
        check("ready_cleared", bus_if.data_ready, 0);
        bus_if.rdn = 1'b1;
        #1 check("data_oe_after_read", bus_if.data_oe, 0);

        // Framing error
        push_rx(EV_FERR, 8'h3C);
        send_rx(8'h55, 1'b0);
        check("ferr_ready_stays_0", bus_if.data_ready, 0);
        check("ferr_data_o_kept", bus_if.data_o, 8'h3C);

        // Overrun
        push_rx(EV_READY, 8'h11);
        push_rx(EV_OVR, 8'h22);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check("ovr_data_o", bus_if.data_o, 8'h22);
        check("ovr_ready", bus_if.data_ready, 1);

        // Read event on the completion edge (measured latency)
        fork
            send_rx(8'h77, 1'b1);
            begin
                @(posedge clk); #1;
                repeat (lat - 1) @(posedge clk);
                #1 bus_if.rdn = 1'b0;
                @(posedge clk);
                #1 bus_if.rdn = 1'b1;
            end
        join
        check("simul_ready", bus_if.data_ready, 1);
        check("simul_data_o", bus_if.data_o, 8'h77);

        // Short glitch on rxd
        @(posedge clk); #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (200) @(posedge clk);
        check("glitch_data_o", bus_if.data_o, 8'h77);
        check("glitch_no_event", rx_q.size(), 0);

        // Reset mid-frame (TX data bit 3, RX data bit 5)
        fork
            send_rx(8'h99, 1'b1);
            begin
                repeat (15) @(posedge clk);
                tx_q.push_back(8'hC3);
                host_write(8'hC3);
            end
            begin
                repeat (53) @(posedge clk);
                #3 rst = 1'b0;
                #1;
                check("rst_txd", txd, 1);
                check("rst_tbre", bus_if.tbre, 1);
                check("rst_tsre", bus_if.tsre, 1);
                check("rst_data_ready", bus_if.data_ready, 0);
            end
        join
        repeat (3) @(posedge clk);
        tx_q.delete();
        rx_q.delete();
        #1 rst = 1'b1;
        tx_q.push_back(8'h5A);
        host_write(8'h5A);
        wait_flag("wait_5a_busy", 1, 1'b0, 10);
        wait_flag("wait_5a_done", 1, 1'b1, 200);
        repeat (5) @(negedge clk);
        check("tx_5a_drained", tx_q.size(), 0);
        check("rx_q_final_empty", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
